// File: rtl/mat_ops_pkg.sv
// Shared constants for the matrix-ops sequencer: state encodings, opcodes,
// and command/status word bit positions.
package mat_ops_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_POLL_WAIT  = 3'd0;
  localparam state_t ST_POLL_CHECK = 3'd1;
  localparam state_t ST_DECODE     = 3'd2;
  localparam state_t ST_START      = 3'd3;
  localparam state_t ST_RUN        = 3'd4;
  localparam state_t ST_NEXT       = 3'd5;
  localparam state_t ST_WB         = 3'd6;
  localparam state_t ST_DONE       = 3'd7;

  localparam logic [1:0] OP_MUL       = 2'b00;
  localparam logic [1:0] OP_ADD       = 2'b01;
  localparam logic [1:0] OP_TRANSPOSE = 2'b10;
  localparam logic [1:0] OP_RSVD      = 2'b11;

  // command word layout
  localparam int CMD_GO_BIT   = 0;
  localparam int CMD_OP_LSB   = 1;
  localparam int CMD_CNT_LSB  = 4;
  localparam int CMD_BASE_LSB = 8;

  // status word layout; bit 0 stays 0 so the write-back clears go
  localparam int STS_DONE_BIT = 1;
  localparam int STS_ERR_BIT  = 2;
  localparam int STS_TMO_BIT  = 3;
  localparam int STS_JOBS_LSB = 8;

  // busy covers every state between accepting a command and writing status
  function automatic logic state_is_busy(state_t s);
    return (s >= ST_DECODE) && (s <= ST_WB);
  endfunction

endpackage

// File: rtl/mat_ops_sequencer_if.sv
// Command-memory and engine start/done bus between the sequencer (master)
// and the memory/engine side (slave).
interface mat_ops_sequencer_if #(
  parameter int DATA_LEN     = 32,
  parameter int ADDRESS_SIZE = 4
);
  logic [ADDRESS_SIZE-1:0] cmd_addr;
  logic [DATA_LEN-1:0]     cmd_rdata;
  logic                    cmd_wr_en;
  logic [DATA_LEN-1:0]     cmd_wdata;
  logic                    eng_start;
  logic [1:0]              eng_op;
  logic [ADDRESS_SIZE-1:0] eng_base;
  logic                    eng_done;

  modport master (
    output cmd_addr, cmd_wr_en, cmd_wdata, eng_start, eng_op, eng_base,
    input  cmd_rdata, eng_done
  );

  modport slave (
    input  cmd_addr, cmd_wr_en, cmd_wdata, eng_start, eng_op, eng_base,
    output cmd_rdata, eng_done
  );
endinterface

// File: rtl/mat_ops_watchdog.sv
// Per-job watchdog: counts enabled cycles from zero and flags when the
// count reaches LIMIT-1. Holds at the limit until cleared.
module mat_ops_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q;

  assign o_expired = (cnt_q == W'(LIMIT - 1));

  // cycle counter, restarted by clear, frozen once expired
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clear) begin
      cnt_q <= '0;
    end else if (i_en && !o_expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mat_ops_sequencer.sv
// Matrix-ops sequencer: polls the command word, runs R engine jobs with a
// striding base address, supervises each job, and writes status back.
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  POLL_WAIT  | idle gap of POLL_INTERVAL cycles between command reads
//  POLL_CHECK | sample command word, capture fields if go=1
//  DECODE     | validate op/count, clear error and job counter
//  START      | one-cycle engine start pulse
//  RUN        | wait for engine done under watchdog and abort
//  NEXT       | count finished job, step base, loop or finish
//  WB         | write status word (clears go)
//  DONE       | one-cycle completion pulse
module mat_ops_sequencer
  import mat_ops_pkg::*;
#(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_SIZE  = 4,
  parameter int CMD_ADDR      = 0,
  parameter int TILE_STRIDE   = 1,
  parameter int POLL_INTERVAL = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_abort,
  mat_ops_sequencer_if.master bus,
  output logic [2:0]          o_state,
  output logic [7:0]          o_job_cnt,
  output logic                o_busy,
  output logic                o_err,
  output logic                o_done
);
  localparam int PW = $clog2(POLL_INTERVAL + 1);

  state_t                  state_q, state_d;
  logic [PW-1:0]           poll_cnt_q;
  logic [1:0]              op_q;
  logic [3:0]              rep_q;
  logic [ADDRESS_SIZE-1:0] base_q;
  logic [ADDRESS_SIZE-1:0] base_nxt;
  logic [1:0]              eng_op_q;
  logic [ADDRESS_SIZE-1:0] eng_base_q;
  logic [7:0]              job_cnt_q;
  logic                    sts_done_q, sts_err_q, sts_tmo_q;
  logic                    err_q;
  logic                    dec_bad;
  logic                    job_last;
  logic                    wd_expired;
  logic [DATA_LEN-1:0]     status_word;
  logic                    rdata_unused;

  assign base_nxt     = base_q + ADDRESS_SIZE'(TILE_STRIDE);
  assign dec_bad      = (op_q == OP_RSVD) || (rep_q == 4'd0);
  assign job_last     = ((job_cnt_q + 8'd1) == {4'd0, rep_q});
  assign rdata_unused = ^bus.cmd_rdata;

  mat_ops_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clear   (state_q == ST_START),
    .i_en      (state_q == ST_RUN),
    .o_expired (wd_expired)
  );

  // next-state decode; abort beats done, done beats the watchdog
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_POLL_WAIT:  if (poll_cnt_q == PW'(POLL_INTERVAL - 1)) state_d = ST_POLL_CHECK;
      ST_POLL_CHECK: state_d = bus.cmd_rdata[CMD_GO_BIT] ? ST_DECODE : ST_POLL_WAIT;
      ST_DECODE:     state_d = dec_bad ? ST_WB : ST_START;
      ST_START:      state_d = ST_RUN;
      ST_RUN: begin
        if (i_abort)           state_d = ST_WB;
        else if (bus.eng_done) state_d = ST_NEXT;
        else if (wd_expired)   state_d = ST_WB;
      end
      ST_NEXT:       state_d = job_last ? ST_WB : ST_START;
      ST_WB:         state_d = ST_DONE;
      ST_DONE:       state_d = ST_POLL_WAIT;
      default:       state_d = ST_POLL_WAIT;
    endcase
  end

  // state register and poll-interval counter
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= ST_POLL_WAIT;
      poll_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_POLL_WAIT && state_d == ST_POLL_WAIT) poll_cnt_q <= poll_cnt_q + 1'b1;
      else                                                    poll_cnt_q <= '0;
    end
  end

  // command fields, job bookkeeping, engine outputs and status bits
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      op_q       <= '0;
      rep_q      <= '0;
      base_q     <= '0;
      eng_op_q   <= '0;
      eng_base_q <= '0;
      job_cnt_q  <= '0;
      sts_done_q <= 1'b0;
      sts_err_q  <= 1'b0;
      sts_tmo_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_POLL_CHECK: begin
          if (bus.cmd_rdata[CMD_GO_BIT]) begin
            op_q   <= bus.cmd_rdata[CMD_OP_LSB +: 2];
            rep_q  <= bus.cmd_rdata[CMD_CNT_LSB +: 4];
            base_q <= bus.cmd_rdata[CMD_BASE_LSB +: ADDRESS_SIZE];
          end
        end
        ST_DECODE: begin
          job_cnt_q  <= '0;
          err_q      <= 1'b0;
          sts_done_q <= 1'b0;
          sts_tmo_q  <= 1'b0;
          sts_err_q  <= dec_bad;
          if (!dec_bad) begin
            eng_op_q   <= op_q;
            eng_base_q <= base_q;
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            sts_err_q <= 1'b1;
          end else if (!bus.eng_done && wd_expired) begin
            sts_err_q <= 1'b1;
            sts_tmo_q <= 1'b1;
          end
        end
        ST_NEXT: begin
          job_cnt_q <= job_cnt_q + 8'd1;
          base_q    <= base_nxt;
          if (job_last) sts_done_q <= 1'b1;
          else          eng_base_q <= base_nxt;
        end
        ST_WB: begin
          if (sts_err_q) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // status word assembled from the sticky status bits and job count
  always_comb begin
    status_word                      = '0;
    status_word[STS_DONE_BIT]        = sts_done_q;
    status_word[STS_ERR_BIT]         = sts_err_q;
    status_word[STS_TMO_BIT]         = sts_tmo_q;
    status_word[STS_JOBS_LSB +: 8]   = job_cnt_q;
  end

  assign bus.cmd_addr  = ADDRESS_SIZE'(CMD_ADDR);
  assign bus.cmd_wr_en = (state_q == ST_WB);
  assign bus.cmd_wdata = status_word;
  assign bus.eng_start = (state_q == ST_START);
  assign bus.eng_op    = eng_op_q;
  assign bus.eng_base  = eng_base_q;

  assign o_state   = state_q;
  assign o_job_cnt = job_cnt_q;
  assign o_busy    = state_is_busy(state_q);
  assign o_err     = err_q;
  assign o_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_mat_ops_sequencer.sv
// Directed bench for mat_ops_sequencer with a one-word command memory model
// and a scripted engine.
module tb_mat_ops_sequencer;
  logic       i_clk;
  logic       i_rstn;
  logic       i_abort;
  logic [2:0] o_state;
  logic [7:0] o_job_cnt;
  logic       o_busy;
  logic       o_err;
  logic       o_done;

  mat_ops_sequencer_if #(.DATA_LEN(32), .ADDRESS_SIZE(4)) bus ();

  mat_ops_sequencer #(
    .DATA_LEN(32), .ADDRESS_SIZE(4), .CMD_ADDR(0), .TILE_STRIDE(1),
    .POLL_INTERVAL(4), .TIMEOUT(16)
  ) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_abort   (i_abort),
    .bus       (bus),
    .o_state   (o_state),
    .o_job_cnt (o_job_cnt),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .o_done    (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // command memory: DUT status write wins over host write
  logic        host_we;
  logic [31:0] host_wdata;
  logic [31:0] mem;
  always @(posedge i_clk) begin
    if (bus.cmd_wr_en) mem <= bus.cmd_wdata;
    else if (host_we)  mem <= host_wdata;
    bus.cmd_rdata <= mem;
  end

  // observation of DUT events, sampled mid-cycle
  int          cyc = 0;
  int          n_starts = 0, n_wr = 0, n_done = 0, n_pc = 0;
  int          start_cyc = 0, pc_go_cyc = 0, last_pc_cyc = 0, pc_gap = 0;
  int          run_entry_cyc = 0, wr_cyc = 0;
  logic [2:0]  prev_state = 3'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [1:0]  start_op   [0:15];
  logic [3:0]  start_base [0:15];
  always @(negedge i_clk) begin
    cyc        <= cyc + 1;
    prev_state <= o_state;
    if (bus.eng_start) begin
      start_op[n_starts[3:0]]   <= bus.eng_op;
      start_base[n_starts[3:0]] <= bus.eng_base;
      n_starts  <= n_starts + 1;
      start_cyc <= cyc;
    end
    if (bus.cmd_wr_en) begin
      n_wr       <= n_wr + 1;
      last_wdata <= bus.cmd_wdata;
      wr_cyc     <= cyc;
    end
    if (o_done) n_done <= n_done + 1;
    if (o_state == 3'd1) begin
      n_pc        <= n_pc + 1;
      pc_gap      <= cyc - last_pc_cyc;
      last_pc_cyc <= cyc;
      if (bus.cmd_rdata[0]) pc_go_cyc <= cyc;
    end
    if (o_state == 3'd4 && prev_state != 3'd4) run_entry_cyc <= cyc;
  end

  task automatic host_write(input logic [31:0] val);
    @(negedge i_clk);
    host_we    = 1'b1;
    host_wdata = val;
    @(negedge i_clk);
    host_we    = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!bus.eng_start && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, {31'd0, bus.eng_start}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk(tag, {31'd0, o_done}, 32'd1);
    @(negedge i_clk);
  endtask

  task automatic pulse_done(input int delay);
    repeat (delay) @(negedge i_clk);
    bus.eng_done = 1'b1;
    @(negedge i_clk);
    bus.eng_done = 1'b0;
  endtask

  int s0, w0, d0;

  initial begin
    i_rstn       = 1'b0;
    i_abort      = 1'b0;
    bus.eng_done = 1'b0;
    host_we      = 1'b1;
    host_wdata   = 32'd0;
    repeat (3) @(negedge i_clk);
    host_we = 1'b0;

    // reset state
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_outs", {26'd0, o_busy, o_err, o_done, bus.cmd_wr_en, bus.eng_start, o_job_cnt != 8'd0}, 32'd0);
    chk("rst_addr", {28'd0, bus.cmd_addr}, 32'd0);
    chk("rst_wdata", bus.cmd_wdata, 32'd0);

    // idle polling
    i_rstn = 1'b1;
    repeat (40) @(negedge i_clk);
    chk("idle_starts", n_starts, 0);
    chk("idle_writes", n_wr, 0);
    chk("idle_poll_gap", pc_gap, 5);
    chk("idle_poll_cnt_min", {31'd0, n_pc >= 7}, 32'd1);

    // single job: op MUL, R=1, base 3
    s0 = n_starts; w0 = n_wr; d0 = n_done;
    host_write(32'h0000_0311);
    wait_start("single_start_seen");
    pulse_done(10);
    wait_done("single_done_seen");
    chk("single_latency", start_cyc - pc_go_cyc, 2);
    chk("single_nstart", n_starts - s0, 1);
    chk("single_op", {30'd0, start_op[s0[3:0]]}, 32'd0);
    chk("single_base", {28'd0, start_base[s0[3:0]]}, 32'd3);
    chk("single_status", last_wdata, 32'h0000_0102);
    chk("single_nwr", n_wr - w0, 1);
    chk("single_ndone", n_done - d0, 1);
    chk("single_err", {31'd0, o_err}, 32'd0);

    // three jobs with wrap: op ADD, R=3, base 14
    s0 = n_starts;
    host_write(32'h0000_0E33);
    for (int j = 0; j < 3; j++) begin
      wait_start("stride_start_seen");
      pulse_done(3);
    end
    wait_done("stride_done_seen");
    chk("stride_base0", {28'd0, start_base[s0[3:0]]}, 32'd14);
    chk("stride_base1", {28'd0, start_base[s0[3:0] + 4'd1]}, 32'd15);
    chk("stride_base2", {28'd0, start_base[s0[3:0] + 4'd2]}, 32'd0);
    chk("stride_op", {30'd0, start_op[s0[3:0] + 4'd2]}, 32'd1);
    chk("stride_status", last_wdata, 32'h0000_0302);
    chk("stride_jobcnt", {24'd0, o_job_cnt}, 32'd3);

    // reserved opcode
    s0 = n_starts;
    host_write(32'h0000_0017);
    wait_done("badop_done_seen");
    chk("badop_nstart", n_starts - s0, 0);
    chk("badop_status", last_wdata, 32'h0000_0004);
    chk("badop_err", {31'd0, o_err}, 32'd1);

    // zero repeat count
    host_write(32'h0000_0001);
    wait_done("zero_done_seen");
    chk("zero_nstart", n_starts - s0, 0);
    chk("zero_status", last_wdata, 32'h0000_0004);
    chk("zero_err", {31'd0, o_err}, 32'd1);

    // timeout: engine never answers
    host_write(32'h0000_0011);
    wait_start("tmo_start_seen");
    @(negedge i_clk);
    chk("tmo_err_cleared", {31'd0, o_err}, 32'd0);
    wait_done("tmo_done_seen");
    chk("tmo_wb_delay", wr_cyc - run_entry_cyc, 16);
    chk("tmo_status", last_wdata, 32'h0000_000C);
    chk("tmo_err", {31'd0, o_err}, 32'd1);

    // abort together with done during job 2 of 3
    s0 = n_starts;
    host_write(32'h0000_0535);
    wait_start("abort_start1_seen");
    pulse_done(2);
    wait_start("abort_start2_seen");
    repeat (2) @(negedge i_clk);
    i_abort      = 1'b1;
    bus.eng_done = 1'b1;
    @(negedge i_clk);
    i_abort      = 1'b0;
    bus.eng_done = 1'b0;
    wait_done("abort_done_seen");
    chk("abort_nstart", n_starts - s0, 2);
    chk("abort_op", {30'd0, start_op[s0[3:0]]}, 32'd2);
    chk("abort_status", last_wdata, 32'h0000_0104);
    chk("abort_jobcnt", {24'd0, o_job_cnt}, 32'd1);
    chk("abort_err", {31'd0, o_err}, 32'd1);

    // reset in the middle of RUN: base 9, R=2
    w0 = n_wr;
    host_write(32'h0000_0921);
    wait_start("rstrun_start_seen");
    pulse_done(2);
    wait_start("rstrun_start2_seen");
    repeat (3) @(negedge i_clk);
    chk("rstrun_in_run", {29'd0, o_state}, 32'd4);
    i_rstn = 1'b0;
    @(negedge i_clk);
    chk("rstrun_state", {29'd0, o_state}, 32'd0);
    chk("rstrun_outs", {28'd0, o_busy, o_err, o_done, bus.eng_start}, 32'd0);
    chk("rstrun_jobcnt", {24'd0, o_job_cnt}, 32'd0);
    chk("rstrun_base", {28'd0, bus.eng_base}, 32'd0);
    host_write(32'h0000_0000);
    i_rstn = 1'b1;
    repeat (12) @(negedge i_clk);
    chk("rstrun_nowrite", n_wr - w0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
